// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle for muldiv_unit.
//   master : drives start/op/a/b and the direct HI/LO write port (hi_we, lo_we, wd);
//            observes busy, done, div_by_zero and the architectural hi/lo registers.
//   slave  : the muldiv_unit side of the same signals.
interface muldiv_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wd;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wd,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wd,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS-style HI/LO multiply/divide unit.
//   op 00 MULT, 01 MULTU: shift-add, one multiplier bit per RUN cycle, {hi,lo} = product.
//   op 10 DIV,  11 DIVU : restoring division, one quotient bit per RUN cycle,
//                         lo = quotient, hi = remainder (signed ops truncate toward zero).
// Ports:
//   clock       - sole clock, rising edge
//   reset       - synchronous, active-low
//   bus (slave) - start/op/a/b request, hi_we/lo_we/wd direct writes,
//                 busy/done/div_by_zero status, hi/lo registers
// Configuration:
//   MULDIV_DIV_EN - when defined, the divider datapath is built. When undefined, DIV/DIVU
//                   are no-ops that pulse done the cycle after start without going busy.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic     clock,
  input logic     reset,
  muldiv_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q;
  logic [WIDTH-1:0]   opnd_q;   // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] work_q;   // {partial product, multiplier} or {remainder, dividend/quotient}
  logic               neg_q;    // negate product / quotient at the end
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               accept;
  logic               last;
  logic               op_signed;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] work_d;
  logic [WIDTH-1:0]   res_hi, res_lo;

`ifdef MULDIV_DIV_EN
  logic               is_div_q;
  logic               rneg_q;   // remainder takes the sign of the dividend
  logic               bzero_q;
  logic [WIDTH-1:0]   a_q;      // raw dividend, returned in hi on divide-by-zero
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
`endif

  assign accept    = (state_q == StIdle) && bus.start;
  assign last      = (state_q == StRun) && (cnt_q == CntW'(WIDTH - 1));
  assign op_signed = ~bus.op[0];
  assign mag_a     = (op_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign mag_b     = (op_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
`ifdef MULDIV_DIV_EN
          state_d = StRun;
`else
          state_d = bus.op[1] ? StFin : StRun;
`endif
        end
      end
      StRun:   if (last) state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // One iteration of the selected algorithm
  always_comb begin
    mul_sum = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
    work_d  = {mul_sum, work_q[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    div_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (is_div_q) begin
      // Negative trial difference means restore: keep the shifted remainder, quotient bit 0
      work_d = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
    end
`endif
  end

  // Sign-corrected result, taken from the final iteration on the edge entering FIN
  always_comb begin
    {res_hi, res_lo} = neg_q ? -work_d : work_d;
`ifdef MULDIV_DIV_EN
    if (is_div_q) begin
      res_lo = neg_q ? -work_d[WIDTH-1:0] : work_d[WIDTH-1:0];
      res_hi = rneg_q ? -work_d[2*WIDTH-1:WIDTH] : work_d[2*WIDTH-1:WIDTH];
      if (bzero_q) begin
        res_lo = '1;
        res_hi = a_q;
      end
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      opnd_q  <= '0;
      work_q  <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q <= '0;
        neg_q <= op_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
`ifdef MULDIV_DIV_EN
        opnd_q <= bus.op[1] ? mag_b : mag_a;
        work_q <= {{WIDTH{1'b0}}, (bus.op[1] ? mag_a : mag_b)};
`else
        opnd_q <= mag_a;
        work_q <= {{WIDTH{1'b0}}, mag_b};
`endif
      end else if (state_q == StRun) begin
        cnt_q  <= cnt_q + 1'b1;
        work_q <= work_d;
      end
      // The result beats a concurrent direct write
      if (last) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else begin
        if (bus.hi_we) hi_q <= bus.wd;
        if (bus.lo_we) lo_q <= bus.wd;
      end
    end
  end

`ifdef MULDIV_DIV_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      is_div_q <= 1'b0;
      rneg_q   <= 1'b0;
      bzero_q  <= 1'b0;
      a_q      <= '0;
    end else if (accept) begin
      is_div_q <= bus.op[1];
      rneg_q   <= op_signed & bus.a[WIDTH-1];
      bzero_q  <= (bus.b == '0);
      a_q      <= bus.a;
    end
  end

  assign bus.div_by_zero = (state_q == StFin) && is_div_q && bzero_q;
`else
  assign bus.div_by_zero = 1'b0;
`endif

  assign bus.busy = (state_q == StRun);
  assign bus.done = (state_q == StFin);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width; only 32 is required to work.
REQ-002 SHALL have port: clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clock.
REQ-004 SHALL have port: start  input  1  request a new operation; honoured only in IDLE.
REQ-005 SHALL have port: op  input  2  operation, sampled with start: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port: a  input  WIDTH  rs operand, sampled with start.
REQ-007 SHALL have port: b  input  WIDTH  rt operand, sampled with start.
REQ-008 SHALL have ports: hi_we  input  1; lo_we  input  1; wd  input  WIDTH  direct HI/LO write (MTHI/MTLO).
REQ-009 SHALL have port: busy  output  1  operation in progress.
REQ-010 SHALL have port: done  output  1  single-cycle completion pulse.
REQ-011 SHALL have port: div_by_zero  output  1  valid only while done=1.
REQ-012 SHALL have ports: hi  output  WIDTH; lo  output  WIDTH  architectural HI/LO registers.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, FIN: IDLE -start-> RUN; RUN -iteration WIDTH-1 complete-> FIN; FIN -> IDLE unconditionally.
REQ-014 SHALL, on the rising edge where state=IDLE and start=1, latch op/a/b; busy=1 for exactly WIDTH cycles; done=1 for the following single cycle (FIN), with busy=0.
REQ-015 SHALL update hi/lo on the edge entering FIN, so new values are visible in the done cycle; hi/lo hold prior values throughout RUN.
REQ-016 SHALL ignore start while busy=1 or done=1; no queueing.
REQ-017 SHALL multiply by shift-add, one bit per RUN cycle; {hi,lo} = full 2*WIDTH-bit product; MULT signed, MULTU unsigned.
REQ-018 SHALL divide by restoring division, one quotient bit per RUN cycle; lo = quotient, hi = remainder.
REQ-019 SHALL, for DIV, operate on magnitudes and then correct signs: quotient negative iff a[31]^b[31]; remainder takes the sign of a (truncation toward zero).
REQ-020 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, give lo=0x80000000, hi=0x00000000, div_by_zero=0.
REQ-021 SHALL, for DIV/DIVU with b=0, still take full latency and give lo=0xFFFFFFFF, hi=a (as sampled), div_by_zero=1 in the done cycle.
REQ-022 SHALL keep div_by_zero=0 outside the done cycle and for all multiply ops.
REQ-023 SHALL apply hi_we/lo_we writes of wd on the next edge in any state; hi/lo values written during RUN are overwritten at FIN; a write in the FIN-entry cycle loses to the result.
REQ-024 SHALL allow start on the same edge that ends FIN? No: start in FIN is ignored; earliest new start is the first IDLE cycle after done.

Reset
REQ-025 SHALL, when reset=0 at a rising edge, force state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, clearing all working registers.
REQ-026 SHALL abort an in-flight operation on reset: no done pulse and no hi/lo update from that operation afterwards.
REQ-027 SHALL give reset priority over start, hi_we and lo_we in the same cycle.

Configuration
REQ-028 SHALL compile the divider datapath only when macro MULDIV_DIV_EN is defined.
REQ-029 SHALL, with MULDIV_DIV_EN defined, behave per REQ-018..REQ-021.
REQ-030 SHALL, without MULDIV_DIV_EN, treat op 10/11 as a no-op: busy never asserts, done pulses on the cycle after start, hi/lo unchanged, div_by_zero=0; multiply unaffected.

Verification
REQ-031 SHALL cover: MULT a=0xFFFFFFFF b=0x00000002 -> after 32 busy cycles, done=1, hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-032 SHALL cover: MULTU a=0xFFFFFFFF b=0x00000002 -> hi=0x00000001, lo=0xFFFFFFFE; hi/lo unchanged during busy.
REQ-033 SHALL cover: DIV a=0xFFFFFFF9 (-7) b=0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7 b=0 -> lo=0xFFFFFFFF, hi=0x00000007, div_by_zero=1.
REQ-034 SHALL cover: start pulsed again at busy cycle 5 with different operands -> ignored, result matches the first operation, exactly one done pulse.
REQ-035 SHALL cover: reset=0 at busy cycle 10 -> next cycle busy=0, hi=lo=0, no done for 40 cycles.
REQ-036 SHALL cover: lo_we=1 wd=0x12345678 in IDLE -> lo=0x12345678 next cycle; same write during RUN -> overwritten by result at done.
